alu_result_stage: RTL

- Registered output stage directly downstream of unit_A.
- Captures unit_A's S, c_out and O, plus the function code f, into a small FIFO.
- Derives N/Z/C/V condition flags and presents result plus flags to the next consumer (register write-back or display) over a valid/ready handshake.
- Decouples the combinational ALU from a consumer that may stall.

---
 rtl/alu_result_stage_pkg.sv | 24 ++
 rtl/alu_result_stage_if.sv | 33 +++
 rtl/alu_flag_gen.sv | 30 +++
 rtl/alu_result_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared constants for the ALU result stage: function codes,
// arithmetic-group mask, flag bit positions and a group-decode helper.
package alu_result_stage_pkg;

  localparam logic [3:0] F_SUM  = 4'b0100;
  localparam logic [3:0] F_SUB  = 4'b0101;
  localparam logic [3:0] F_AINV = 4'b0110;
  localparam logic [3:0] F_INC  = 4'b0111;

  localparam logic [1:0] ARITH_GRP = 2'b01;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  // F_SUM..F_INC are exactly the codes with f[3:2] == ARITH_GRP
  function automatic logic is_arith(input logic [3:0] f);
    return f[3:2] == ARITH_GRP;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between unit_A, the result stage and its consumer.
// slave: stage view; master: producer/consumer (test) view.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s_in;
  logic             c_in;
  logic             o_in;
  logic [3:0]       f_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, s_in, c_in, o_in, f_in,
    input  out_ready,
    output in_ready, out_valid, result, flags, count
  );

  modport master (
    output in_valid, s_in, c_in, o_in, f_in,
    output out_ready,
    input  in_ready, out_valid, result, flags, count
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation from unit_A outputs.
// Ports: s_in, c_in, o_in, f_in in; flags {N,Z,C,V} out.
module alu_flag_gen
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  input  logic             o_in,
  input  logic [3:0]       f_in,
  output flags_t           flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = s_in[WIDTH-1];
    flags[FLAG_Z] = (s_in == '0);
    // carry/overflow only mean something for arithmetic codes;
    // sub carry is no-borrow and passes through as-is
    unique case (1'b1)
      is_arith(f_in): begin
        flags[FLAG_C] = c_in;
        flags[FLAG_V] = o_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered FIFO output stage behind unit_A: stores result+flags.
// Ports: clk, rst_n (sync, active-low), bus (slave modport).
// Option ALU_STICKY_OV_EN adds clr_sticky in, sticky_v out.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ALU_STICKY_OV_EN
  input  logic clr_sticky,
  output logic sticky_v,
`endif
  alu_result_stage_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  flags_t           flg_q  [DEPTH];
  flags_t           flg_d  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  flags_t new_flags;
  logic   push;
  logic   pop;

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .s_in (bus.s_in),
    .c_in (bus.c_in),
    .o_in (bus.o_in),
    .f_in (bus.f_in),
    .flags(new_flags)
  );

  assign bus.in_ready  = (count_q != CW'(DEPTH)) && rst_n;
  assign bus.out_valid = (count_q != '0);
  assign bus.result    = data_q[rd_ptr_q];
  assign bus.flags     = flg_q[rd_ptr_q];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    data_d   = data_q;
    flg_d    = flg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      data_d[wr_ptr_q] = bus.s_in;
      flg_d[wr_ptr_q]  = new_flags;
      // power-of-two depth: natural wrap
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '{default: '0};
      flg_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      flg_q    <= flg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef ALU_STICKY_OV_EN
  logic sticky_q, sticky_d;

  // set has priority over clear
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (push && new_flags[FLAG_V]) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`endif

endmodule
